// File: rtl/rifl_tx_ctrl.sv
// rifl_tx_ctrl: RIFL transmit-side frame selector with pause, retransmit and replay control.
//   Parameter CTRL_BURST (2..15): minimum back-to-back PAUSE/RETRANS key frames per burst.
//   Inputs : clk, rst_n (async, active-low), tx_up, local_pause_req, local_retrans_req,
//            remote_pause_req, remote_retrans_req, data_valid
//   Outputs: data_ready, frame_sel (00 DATA, 01 IDLE, 10 PAUSE_KEY, 11 RETRANS_KEY),
//            rewind (replay pointer reset pulse), retrans_cnt (saturating RETRANS burst count)
module rifl_tx_ctrl #(
    parameter int CTRL_BURST = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_up,
    input  logic        local_pause_req,
    input  logic        local_retrans_req,
    input  logic        remote_pause_req,
    input  logic        remote_retrans_req,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [1:0]  frame_sel,
    output logic        rewind,
    output logic [15:0] retrans_cnt
);
    typedef enum logic [2:0] {LINK_DOWN, RUN, PAUSE, RETRANS, REPLAY} state_t;

    localparam logic [1:0] SEL_DATA  = 2'b00;
    localparam logic [1:0] SEL_IDLE  = 2'b01;
    localparam logic [1:0] SEL_PAUSE = 2'b10;
    localparam logic [1:0] SEL_RETR  = 2'b11;
    localparam logic [3:0] BURST_MAX  = 4'(CTRL_BURST);
    localparam logic [3:0] BURST_LAST = 4'(CTRL_BURST - 1);

    state_t      state, nxt_state;
    logic [3:0]  burst;
    logic        pend, pend_eff, burst_done, decide, enter, nxt_rewind;
    logic [1:0]  nxt_sel;

    // A request seen this cycle acts immediately, as if it were already latched.
    assign pend_eff   = pend | local_retrans_req;
    // Counter starts at 0 on entry, so CTRL_BURST key cycles have elapsed when it reaches CTRL_BURST-1.
    assign burst_done = burst >= BURST_LAST;
    // States in which the normal RUN priority chain picks the next frame.
    assign decide = (state == RUN) || (state == REPLAY) ||
                    (state == RETRANS && burst_done) ||
                    (state == PAUSE && burst_done && (pend_eff || !local_pause_req));

    always_comb begin
        nxt_state  = state;
        nxt_sel    = frame_sel;
        nxt_rewind = 1'b0;
        enter      = 1'b0;
        if (!tx_up) begin
            nxt_state = LINK_DOWN;
            nxt_sel   = SEL_IDLE;
        end else if (state == LINK_DOWN) begin
            nxt_state = RUN;
            nxt_sel   = SEL_IDLE;
            enter     = 1'b1;
        end else if (decide) begin
            if (pend_eff) begin
                nxt_state = RETRANS;
                nxt_sel   = SEL_RETR;
                enter     = 1'b1;
            end else if (local_pause_req) begin
                nxt_state = PAUSE;
                nxt_sel   = SEL_PAUSE;
                enter     = 1'b1;
            end else if (remote_retrans_req) begin
                nxt_state  = REPLAY;
                nxt_sel    = SEL_IDLE;
                nxt_rewind = state != REPLAY;
                enter      = state != REPLAY;
            end else begin
                nxt_state = RUN;
                nxt_sel   = (remote_pause_req || !data_valid) ? SEL_IDLE : SEL_DATA;
                enter     = state != RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LINK_DOWN;
            frame_sel   <= SEL_IDLE;
            data_ready  <= 1'b0;
            rewind      <= 1'b0;
            retrans_cnt <= 16'd0;
            pend        <= 1'b0;
            burst       <= 4'd0;
        end else begin
            state      <= nxt_state;
            frame_sel  <= nxt_sel;
            data_ready <= nxt_sel == SEL_DATA;
            rewind     <= nxt_rewind;
            burst      <= (enter || nxt_state == LINK_DOWN) ? 4'd0 :
                          (burst == BURST_MAX) ? burst : burst + 4'd1;
            // Entering RETRANS consumes the pending request; later requests re-arm it.
            pend       <= !tx_up ? 1'b0 : (enter && nxt_state == RETRANS) ? 1'b0 : pend_eff;
            if (enter && nxt_state == RETRANS && retrans_cnt != 16'hFFFF)
                retrans_cnt <= retrans_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_rifl_tx_ctrl.sv
// tb_rifl_tx_ctrl: directed-vector bench with a cycle-level behavioural model of rifl_tx_ctrl.
module tb_rifl_tx_ctrl;
    localparam int B = 8;

    logic        clk, rst_n, tx_up, local_pause_req, local_retrans_req;
    logic        remote_pause_req, remote_retrans_req, data_valid;
    logic        data_ready, rewind;
    logic [1:0]  frame_sel;
    logic [15:0] retrans_cnt;

    int checks = 0;
    int failures = 0;

    rifl_tx_ctrl #(.CTRL_BURST(B)) dut (
        .clk(clk), .rst_n(rst_n), .tx_up(tx_up),
        .local_pause_req(local_pause_req), .local_retrans_req(local_retrans_req),
        .remote_pause_req(remote_pause_req), .remote_retrans_req(remote_retrans_req),
        .data_valid(data_valid), .data_ready(data_ready), .frame_sel(frame_sel),
        .rewind(rewind), .retrans_cnt(retrans_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 down, 1 run, 2 pause, 3 retrans, 4 replay; m_left = key cycles still owed.
    int m_mode, m_left, m_pend, m_sel, m_rew, m_rc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_pend = 0; m_sel = 1; m_rew = 0; m_rc = 0;
    endtask

    task automatic model_decide(input int pe);
        if (pe != 0) begin
            m_mode = 3; m_sel = 3; m_left = B - 1; m_pend = 0;
            if (m_rc < 65535) m_rc++;
        end else begin
            m_pend = 0;
            if (local_pause_req) begin
                m_mode = 2; m_sel = 2; m_left = B - 1;
            end else if (remote_retrans_req) begin
                m_rew = (m_mode != 4) ? 1 : 0;
                m_mode = 4; m_sel = 1;
            end else begin
                m_mode = 1;
                m_sel = (remote_pause_req || !data_valid) ? 1 : 0;
            end
        end
    endtask

    task automatic model_step();
        int pe;
        m_rew = 0;
        if (!tx_up) begin
            m_mode = 0; m_sel = 1; m_pend = 0; m_left = 0;
            return;
        end
        pe = (m_pend != 0 || local_retrans_req) ? 1 : 0;
        if (m_mode == 0) begin
            m_mode = 1; m_sel = 1; m_pend = pe;
        end else if (m_mode == 3 && m_left > 0) begin
            m_left--; m_pend = pe;
        end else if (m_mode == 2 && (m_left > 0 || (local_pause_req && pe == 0))) begin
            if (m_left > 0) m_left--;
            m_pend = pe;
        end else begin
            model_decide(pe);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        #1;
    endtask

    task automatic count_sel(input int n, input logic [1:0] s, output int c, output int r);
        c = 0; r = 0;
        repeat (n) begin
            tick();
            if (frame_sel == s) c++;
            if (rewind) r++;
        end
    endtask

    always @(negedge clk) begin
        chk("frame_sel", int'(frame_sel), m_sel);
        chk("data_ready", int'(data_ready), (m_sel == 0) ? 1 : 0);
        chk("rewind", int'(rewind), m_rew);
        chk("retrans_cnt", int'(retrans_cnt), m_rc);
    end

    initial begin
        int a, b, ra, rb, rc2;
        rst_n = 0; tx_up = 1; data_valid = 1;
        local_pause_req = 0; local_retrans_req = 0; remote_pause_req = 0; remote_retrans_req = 0;
        model_reset();
        tick(); tick();
        chk("reset_sel", int'(frame_sel), 1);
        rst_n = 1;
        tick();
        chk("cycle1_idle", int'(frame_sel), 1);
        tick();
        chk("cycle2_data", int'(frame_sel), 0);
        chk("cycle2_ready", int'(data_ready), 1);
        repeat (3) tick();
        // single retrans pulse
        local_retrans_req = 1; count_sel(1, 2'b11, a, ra);
        local_retrans_req = 0; count_sel(11, 2'b11, b, rb);
        chk("retrans_len", a + b, 8);
        chk("retrans_cnt1", int'(retrans_cnt), 1);
        chk("retrans_after", int'(frame_sel), 0);
        // short and long pause
        local_pause_req = 1; count_sel(3, 2'b10, a, ra);
        local_pause_req = 0; count_sel(12, 2'b10, b, rb);
        chk("pause3_len", a + b, 8);
        local_pause_req = 1; count_sel(20, 2'b10, a, ra);
        local_pause_req = 0; count_sel(12, 2'b10, b, rb);
        chk("pause20_len", a + b, 20);
        chk("pause20_after", int'(frame_sel), 0);
        // remote replay
        remote_retrans_req = 1; count_sel(30, 2'b01, a, ra);
        remote_retrans_req = 0; count_sel(5, 2'b01, b, rb);
        chk("replay_idle", a + b, 30);
        chk("replay_rewinds", ra + rb, 1);
        chk("replay_after", int'(frame_sel), 0);
        // replay preempted by pause, then re-entered
        remote_retrans_req = 1; count_sel(3, 2'b01, a, ra);
        local_pause_req = 1; count_sel(1, 2'b10, b, rb);
        local_pause_req = 0; count_sel(12, 2'b01, a, rc2);
        chk("replay_reentry_rewinds", ra + rb + rc2, 2);
        remote_retrans_req = 0; repeat (3) tick();
        // simultaneous retrans + pause
        local_retrans_req = 1; local_pause_req = 1; tick();
        local_retrans_req = 0; repeat (7) tick();
        chk("simul_retrans_last", int'(frame_sel), 3);
        tick();
        chk("simul_then_pause", int'(frame_sel), 2);
        local_pause_req = 0; repeat (10) tick();
        // request during RETRANS re-arms a second burst
        local_retrans_req = 1; count_sel(1, 2'b11, a, ra);
        local_retrans_req = 0; count_sel(2, 2'b11, b, rb); a += b;
        local_retrans_req = 1; count_sel(1, 2'b11, b, rb); a += b;
        local_retrans_req = 0; count_sel(16, 2'b11, b, rb);
        chk("rearm_len", a + b, 16);
        // retrans request during pause burst
        local_pause_req = 1; tick();
        local_retrans_req = 1; tick();
        local_retrans_req = 0; repeat (12) tick();
        local_pause_req = 0; repeat (12) tick();
        // idle conditions
        data_valid = 0; tick();
        chk("no_valid_idle", int'(frame_sel), 1);
        data_valid = 1; remote_pause_req = 1; repeat (3) tick();
        chk("remote_pause_idle", int'(frame_sel), 1);
        remote_pause_req = 0; repeat (2) tick();
        // link drop mid-RETRANS
        local_retrans_req = 1; tick();
        local_retrans_req = 0; repeat (4) tick();
        tx_up = 0; tick();
        chk("linkdown_sel", int'(frame_sel), 1);
        chk("linkdown_ready", int'(data_ready), 0);
        repeat (2) tick();
        tx_up = 1; tick(); tick();
        chk("linkup_no_retrans", int'(frame_sel), 0);
        repeat (2) tick();
        // async reset mid-PAUSE
        local_pause_req = 1; repeat (3) tick();
        #2 rst_n = 0; model_reset();
        #1;
        chk("async_sel", int'(frame_sel), 1);
        chk("async_ready", int'(data_ready), 0);
        chk("async_rewind", int'(rewind), 0);
        chk("async_cnt", int'(retrans_cnt), 0);
        local_pause_req = 0; tick();
        rst_n = 1; tick();
        chk("post_reset_idle", int'(frame_sel), 1);
        tick();
        chk("post_reset_data", int'(frame_sel), 0);
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rifl_tx_ctrl.md
RIFL_TX_CTRL -- requirements
Module: rifl_tx_ctrl

Interface
REQ-001 SHALL have parameter CTRL_BURST, default 8, minimum consecutive PAUSE/RETRANS control frames per burst (2..15).
REQ-002 SHALL have ports as below:
clk  in  1  transmit clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
tx_up  in  1  link up; low forces link-down behaviour
local_pause_req  in  1  local receive buffer near full (level)
local_retrans_req  in  1  local CRC/receive error (pulse or level)
remote_pause_req  in  1  remote peer pause state (level)
remote_retrans_req  in  1  remote peer retransmit state (level)
data_valid  in  1  upstream frame available
data_ready  out  1  upstream frame consumed this cycle
frame_sel  out  2  00 DATA, 01 IDLE, 10 PAUSE_KEY, 11 RETRANS_KEY
rewind  out  1  one-cycle pulse: replay buffer read pointer returns to oldest unacknowledged frame
retrans_cnt  out  16  saturating count of RETRANS bursts sent

Function
REQ-003 SHALL implement states LINK_DOWN, RUN, PAUSE, RETRANS, REPLAY; all outputs registered, one-cycle latency from inputs.
REQ-004 SHALL go to LINK_DOWN from any state the cycle after tx_up is low; in LINK_DOWN: frame_sel=IDLE, data_ready=0, burst counter=0, retrans pending cleared; exit to RUN when tx_up high.
REQ-005 SHALL latch local_retrans_req high into a retrans-pending flag, held until RETRANS is entered; a request arriving while in RETRANS SHALL set the flag again.
REQ-006 RUN priority, highest first: pending retrans -> RETRANS; local_pause_req -> PAUSE; remote_retrans_req -> REPLAY; remote_pause_req or !data_valid -> frame_sel=IDLE in RUN; otherwise frame_sel=DATA.
REQ-007 data_ready SHALL equal 1 exactly in cycles where frame_sel=DATA; DATA SHALL never be selected unless data_valid was high the previous cycle.
REQ-008 RETRANS: frame_sel=RETRANS_KEY for exactly CTRL_BURST consecutive cycles, not interruptible except by tx_up low/reset; then RUN; retrans_cnt increments by 1 on entry, saturates at 0xFFFF.
REQ-009 PAUSE: frame_sel=PAUSE_KEY for at least CTRL_BURST cycles; leave when burst counter done and local_pause_req low (-> RUN), or when burst done and retrans pending (-> RETRANS).
REQ-010 REPLAY: rewind pulses high for exactly the first cycle of REPLAY; frame_sel=IDLE, data_ready=0 while remote_retrans_req high; -> RUN the cycle after it goes low; pending retrans or local_pause_req preempt with same priority as REQ-006.
REQ-011 Re-entry to REPLAY after preemption SHALL issue a new rewind pulse; rewind is idempotent downstream.
REQ-012 Burst counter SHALL be 4 bits, reset to 0 on every state entry, saturate at CTRL_BURST.
REQ-013 Simultaneous local_retrans_req and local_pause_req in RUN: RETRANS first, then PAUSE if pause still asserted.

Reset
REQ-014 rst_n low SHALL asynchronously set state=LINK_DOWN, frame_sel=01, data_ready=0, rewind=0, retrans_cnt=0, pending=0, burst counter=0.
REQ-015 Deassertion SHALL take effect on the first rising clk edge after rst_n high; reset mid-burst aborts the burst with no residual pending.

Verification
REQ-016 tx_up=1, data_valid=1, no requests -> frame_sel=00, data_ready=1 every cycle from cycle 2.
REQ-017 1-cycle local_retrans_req pulse in RUN, CTRL_BURST=8 -> exactly 8 cycles of frame_sel=11, data_ready=0, retrans_cnt=1, then frame_sel=00.
REQ-018 local_pause_req high 3 cycles -> 8 cycles of frame_sel=10; high 20 cycles -> PAUSE_KEY until the cycle after deassertion.
REQ-019 remote_retrans_req high 30 cycles -> single rewind pulse, 30 cycles of frame_sel=01, data_ready=0, then DATA resumes.
REQ-020 tx_up dropped mid-RETRANS at burst count 4 -> frame_sel=01 next cycle; on tx_up return, RUN with no RETRANS burst pending.
REQ-021 rst_n asserted mid-PAUSE, no clk edge -> outputs at reset values immediately.
